// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator (640x480@60 by default) with a PIX_LAT-aligned RGB565 output stage.
// Define VGA_CTRL_PATTERN_EN to build the 8-bar test pattern selected by pattern_on.
module vga_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    input  logic        pattern_on,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        de,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_active;
    logic       w_hsync;
    logic       w_vsync;

    assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));
    assign w_active = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    assign w_hsync  = !((r_h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                        (r_h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vsync  = !((r_v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                        (r_v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));

    assign pix_x      = w_active ? r_h_cnt : '1;
    assign pix_y      = w_active ? r_v_cnt : '1;
    assign frame_tick = w_h_last && w_v_last;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Element 0 of each *_pipe is the live value; element PIX_LAT lines up with pix_data.
    logic [PIX_LAT-1:0] r_act_d;
    logic [PIX_LAT-1:0] r_hs_d;
    logic [PIX_LAT-1:0] r_vs_d;
    logic [PIX_LAT:0]   w_act_pipe;
    logic [PIX_LAT:0]   w_hs_pipe;
    logic [PIX_LAT:0]   w_vs_pipe;

    assign w_act_pipe = {r_act_d, w_active};
    assign w_hs_pipe  = {r_hs_d, w_hsync};
    assign w_vs_pipe  = {r_vs_d, w_vsync};

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_act_d <= '0;
            r_hs_d  <= '1;
            r_vs_d  <= '1;
        end else begin
            r_act_d <= w_act_pipe[PIX_LAT-1:0];
            r_hs_d  <= w_hs_pipe[PIX_LAT-1:0];
            r_vs_d  <= w_vs_pipe[PIX_LAT-1:0];
        end
    end

    logic [15:0] w_pix;

`ifdef VGA_CTRL_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [PIX_LAT-1:0][9:0] r_hc_d;
    logic [PIX_LAT:0][9:0]   w_hc_pipe;
    logic [2:0]              w_bar_idx;
    logic [15:0]             w_bar_rgb;

    assign w_hc_pipe = {r_hc_d, r_h_cnt};
    assign w_bar_idx = 3'(w_hc_pipe[PIX_LAT] / 10'(BAR_W));

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hc_d <= '0;
        end else begin
            r_hc_d <= w_hc_pipe[PIX_LAT-1:0];
        end
    end

    always_comb begin
        w_bar_rgb = '0;
        case (w_bar_idx)
            3'd0: w_bar_rgb = 16'hFFFF;
            3'd1: w_bar_rgb = 16'hFFE0;
            3'd2: w_bar_rgb = 16'h07FF;
            3'd3: w_bar_rgb = 16'h07E0;
            3'd4: w_bar_rgb = 16'hF81F;
            3'd5: w_bar_rgb = 16'hF800;
            3'd6: w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    assign w_pix = pattern_on ? w_bar_rgb : pix_data;
`else
    logic w_unused_pattern;
    assign w_unused_pattern = pattern_on;
    assign w_pix            = pix_data;
`endif

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= w_act_pipe[PIX_LAT] ? w_pix : '0;
            de    <= w_act_pipe[PIX_LAT];
            hsync <= w_hs_pipe[PIX_LAT];
            vsync <= w_vs_pipe[PIX_LAT];
        end
    end

endmodule
